vga_frame_reader: RTL

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 102 ++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - 640x480 VGA scan generator that paints one framebuffer cell per 16x16 block
module vga_frame_reader #(
    parameter int CELL_SHIFT = 4,
    parameter int COLS       = 40,
    parameter int ROWS       = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [15:0] oReadAddress,
    input  logic [2:0]  iReadData,
    output logic        oRed,
    output logic        oGreen,
    output logic        oBlue,
    output logic        oHSync,
    output logic        oVSync,
    output logic        oFrameStart
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    logic [9:0]  h;
    logic [9:0]  v;
    logic [15:0] cell_col;
    logic [15:0] cell_row;
    logic        visible;
    logic        hsync_raw;
    logic        vsync_raw;
    logic        frame_start_raw;

    // Stage-1 flags travel alongside the outstanding framebuffer read
    logic        vis_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        frame_start_q;

    // Decode the current scan position; the cell bound check keeps the address inside the framebuffer
    always_comb begin
        cell_col        = 16'(h >> CELL_SHIFT);
        cell_row        = 16'(v >> CELL_SHIFT);
        visible         = (h < H_VISIBLE) && (v < V_VISIBLE) &&
                          (cell_col < 16'(COLS)) && (cell_row < 16'(ROWS));
        hsync_raw       = !((h >= H_SYNC_START) && (h <= H_SYNC_END));
        vsync_raw       = !((v >= V_SYNC_START) && (v <= V_SYNC_END));
        frame_start_raw = (h == 10'd0) && (v == 10'd0);
        oReadAddress    = visible ? (cell_row * 16'(COLS) + cell_col) : 16'd0;
    end

    // Horizontal/vertical scan counters, wrapping straight from the last pixel to (0,0)
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (h == H_LAST) begin
            h <= 10'd0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // Stage 1: hold position-derived flags while the RAM returns the cell color
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            vis_q         <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            vis_q         <= visible;
            hsync_q       <= hsync_raw;
            vsync_q       <= vsync_raw;
            frame_start_q <= frame_start_raw;
        end
    end

    // Stage 2: register color (blanked outside the visible area) together with aligned syncs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oRed        <= 1'b0;
            oGreen      <= 1'b0;
            oBlue       <= 1'b0;
            oHSync      <= 1'b1;
            oVSync      <= 1'b1;
            oFrameStart <= 1'b0;
        end else begin
            oRed        <= vis_q & iReadData[2];
            oGreen      <= vis_q & iReadData[1];
            oBlue       <= vis_q & iReadData[0];
            oHSync      <= hsync_q;
            oVSync      <= vsync_q;
            oFrameStart <= frame_start_q;
        end
    end

endmodule
